// File: rtl/ram_stream_port.sv
// ram_stream_port: block mover between a valid/ready stream and a ram512-class memory (LOAD/DUMP).
// Define RAM_STREAM_PORT_VERIFY_EN to add a post-LOAD readback checksum pass driving o_verify_err.
module ram_stream_port #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_s_valid,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_s_ready,
  output logic              o_m_valid,
  output logic [DATA_W-1:0] o_m_data,
  input  logic              i_m_ready,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_in,
  output logic              o_mem_load,
  input  logic [DATA_W-1:0] i_mem_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_verify_err
);

`ifdef RAM_STREAM_PORT_VERIFY_EN
  typedef enum logic [2:0] {StIdle, StLoad, StDump, StVerify, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StDump, StDone} state_e;
`endif

  localparam logic [CNT_W-1:0] MaxCount = CNT_W'(2 ** ADDR_W);

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [CNT_W-1:0]    r_rem, w_rem_next;
  logic [DATA_W-1:0]   r_m_data, w_m_data_next;
  logic                r_m_valid, w_m_valid_next;
  logic [CNT_W-1:0]    w_count_clamp;

`ifdef RAM_STREAM_PORT_VERIFY_EN
  logic [ADDR_W-1:0]   r_base, w_base_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [DATA_W-1:0]   r_sum_w, w_sum_w_next;
  logic [DATA_W-1:0]   r_sum_r, w_sum_r_next;
  logic                r_verify_err, w_verify_err_next;
`endif

  assign w_count_clamp = (i_count > MaxCount) ? MaxCount : i_count;

  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_rem_next     = r_rem;
    w_m_data_next  = r_m_data;
    w_m_valid_next = r_m_valid;
    o_s_ready      = 1'b0;
    o_mem_load     = 1'b0;
`ifdef RAM_STREAM_PORT_VERIFY_EN
    w_base_next       = r_base;
    w_cnt_next        = r_cnt;
    w_sum_w_next      = r_sum_w;
    w_sum_r_next      = r_sum_r;
    w_verify_err_next = r_verify_err;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_addr_next = i_base_addr;
          w_rem_next  = w_count_clamp;
          if (i_count == '0) begin
            w_state_next = StDone;
          end else if (i_mode) begin
            w_state_next = StDump;
          end else begin
            w_state_next = StLoad;
          end
`ifdef RAM_STREAM_PORT_VERIFY_EN
          w_base_next       = i_base_addr;
          w_cnt_next        = w_count_clamp;
          w_sum_w_next      = '0;
          w_sum_r_next      = '0;
          w_verify_err_next = 1'b0;
`endif
        end
      end
      StLoad: begin
        if (r_rem != '0) begin
          // Reset gates the write strobe so a mid-transfer reset never corrupts memory.
          o_s_ready  = !i_rst;
          o_mem_load = i_s_valid && !i_rst;
          if (i_s_valid) begin
            w_addr_next = r_addr + ADDR_W'(1);
            w_rem_next  = r_rem - CNT_W'(1);
`ifdef RAM_STREAM_PORT_VERIFY_EN
            w_sum_w_next = r_sum_w + i_s_data;
`endif
          end
        end else begin
`ifdef RAM_STREAM_PORT_VERIFY_EN
          w_state_next = StVerify;
          w_addr_next  = r_base;
          w_rem_next   = r_cnt;
`else
          w_state_next = StDone;
`endif
        end
      end
      StDump: begin
        // Entry (nothing held) or handshake: either fetch the next word or finish.
        if (!r_m_valid || i_m_ready) begin
          if (r_m_valid && (r_rem == '0)) begin
            w_m_valid_next = 1'b0;
            w_state_next   = StDone;
          end else begin
            w_m_data_next  = i_mem_out;
            w_m_valid_next = 1'b1;
            w_addr_next    = r_addr + ADDR_W'(1);
            w_rem_next     = r_rem - CNT_W'(1);
          end
        end
      end
`ifdef RAM_STREAM_PORT_VERIFY_EN
      StVerify: begin
        if (r_rem != '0) begin
          w_sum_r_next = r_sum_r + i_mem_out;
          w_addr_next  = r_addr + ADDR_W'(1);
          w_rem_next   = r_rem - CNT_W'(1);
        end else begin
          w_verify_err_next = (r_sum_w != r_sum_r);
          w_state_next      = StDone;
        end
      end
`endif
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_rem     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_addr    <= w_addr_next;
      r_rem     <= w_rem_next;
      r_m_data  <= w_m_data_next;
      r_m_valid <= w_m_valid_next;
    end
  end

`ifdef RAM_STREAM_PORT_VERIFY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base       <= '0;
      r_cnt        <= '0;
      r_sum_w      <= '0;
      r_sum_r      <= '0;
      r_verify_err <= 1'b0;
    end else begin
      r_base       <= w_base_next;
      r_cnt        <= w_cnt_next;
      r_sum_w      <= w_sum_w_next;
      r_sum_r      <= w_sum_r_next;
      r_verify_err <= w_verify_err_next;
    end
  end
  assign o_verify_err = r_verify_err;
`else
  assign o_verify_err = 1'b0;
`endif

  assign o_mem_address = r_addr;
  assign o_mem_in      = i_s_data;
  assign o_m_valid     = r_m_valid;
  assign o_m_data      = r_m_data;
  assign o_busy        = (r_state != StIdle);
  assign o_done        = (r_state == StDone);

endmodule

// File: tb/tb_ram_stream_port.sv
// tb_ram_stream_port: directed bench for ram_stream_port with a behavioural ram512 model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ram_stream_port;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int CW = 10;
`ifdef RAM_STREAM_PORT_VERIFY_EN
  localparam bit VerifyOn = 1'b1;
`else
  localparam bit VerifyOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] base = '0;
  logic [CW-1:0] count = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in;
  logic          mem_load;
  logic [DW-1:0] mem_out;
  logic          busy;
  logic          done;
  logic          verify_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_stream_port #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_base_addr(base),
    .i_count(count), .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(s_ready),
    .o_m_valid(m_valid), .o_m_data(m_data), .i_m_ready(m_ready),
    .o_mem_address(mem_address), .o_mem_in(mem_in), .o_mem_load(mem_load),
    .i_mem_out(mem_out), .o_busy(busy), .o_done(done), .o_verify_err(verify_err)
  );

  // ram512 model: synchronous write, combinational read; ext port lets the bench poke words.
  logic [DW-1:0] ram [512];
  logic          ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_data = '0;
  int            wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_load) begin
      ram[mem_address] <= mem_in;
      wr_cnt <= wr_cnt + 1;
    end else if (ext_we) begin
      ram[ext_addr] <= ext_data;
    end
  end
  assign mem_out = ram[mem_address];

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic ext_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ext_we = 1'b1; ext_addr = a; ext_data = d;
    adv();
    ext_we = 1'b0;
  endtask

  task automatic do_start(input logic md, input logic [AW-1:0] b, input logic [CW-1:0] c);
    start = 1'b1; mode = md; base = b; count = c;
    adv();
    start = 1'b0;
  endtask

  // Returns cycles elapsed until done is seen (sampled at that cycle's falling edge), -1 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      mid();
      if (done === 1'b1) return;
      adv();
      n++;
    end
    n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adv();
    adv();
    mid();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    n_cmp++; if (mem_load !== 1'b0) begin n_err++; $display("FAIL rst_mem_load got=%b exp=0", mem_load); end
    n_cmp++; if (verify_err !== 1'b0) begin n_err++; $display("FAIL rst_verr got=%b exp=0", verify_err); end
    n_cmp++; if (m_data !== 16'h0) begin n_err++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
    n_cmp++; if (mem_address !== 9'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", mem_address); end
    rst = 1'b0;
    adv();
  endtask

  task automatic test_load();
    logic [DW-1:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    int snap;
    int n;
    snap = wr_cnt;
    do_start(1'b0, 9'h005, 10'd4);
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = words[i];
      mid();
      n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL load_s_ready[%0d] got=%b exp=1", i, s_ready); end
      n_cmp++; if (mem_load !== 1'b1) begin n_err++; $display("FAIL load_we[%0d] got=%b exp=1", i, mem_load); end
      n_cmp++; if (mem_address !== AW'(5 + i)) begin
        n_err++; $display("FAIL load_addr[%0d] got=%h exp=%h", i, mem_address, 5 + i);
      end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL load_busy[%0d] got=%b exp=1", i, busy); end
      adv();
    end
    s_data = 16'hBEEF;
    mid();
    n_cmp++; if (mem_load !== 1'b0) begin n_err++; $display("FAIL load_extra_we got=%b exp=0", mem_load); end
    adv();
    s_valid = 1'b0;
    wait_done(n);
    n_cmp++; if (5 + n !== (VerifyOn ? 10 : 5)) begin
      n_err++; $display("FAIL load_done_latency got=%0d exp=%0d", 5 + n, VerifyOn ? 10 : 5);
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL load_busy_at_done got=%b exp=1", busy); end
    n_cmp++; if (verify_err !== 1'b0) begin n_err++; $display("FAIL load_verr got=%b exp=0", verify_err); end
    adv();
    mid();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL load_busy_after got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL load_done_after got=%b exp=0", done); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (ram[5 + i] !== words[i]) begin
        n_err++; $display("FAIL load_ram[%0d] got=%h exp=%h", 5 + i, ram[5 + i], words[i]);
      end
    end
    n_cmp++; if (wr_cnt - snap !== 4) begin n_err++; $display("FAIL load_wr_cnt got=%0d exp=4", wr_cnt - snap); end
    adv();
  endtask

  task automatic test_dump_wrap();
    logic [DW-1:0] exp_d [4] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
    logic [AW-1:0] exp_a [4] = '{9'h1FF, 9'h000, 9'h001, 9'h002};
    ext_write(9'h1FE, 16'h000A);
    ext_write(9'h1FF, 16'h000B);
    ext_write(9'h000, 16'h000C);
    ext_write(9'h001, 16'h000D);
    m_ready = 1'b1;
    do_start(1'b1, 9'h1FE, 10'd4);
    mid();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL dump_entry_valid got=%b exp=0", m_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dump_entry_busy got=%b exp=1", busy); end
    n_cmp++; if (mem_address !== 9'h1FE) begin
      n_err++; $display("FAIL dump_entry_addr got=%h exp=1fe", mem_address);
    end
    adv();
    for (int i = 0; i < 4; i++) begin
      mid();
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL dump_valid[%0d] got=%b exp=1", i, m_valid); end
      n_cmp++; if (m_data !== exp_d[i]) begin
        n_err++; $display("FAIL dump_data[%0d] got=%h exp=%h", i, m_data, exp_d[i]);
      end
      n_cmp++; if (mem_address !== exp_a[i]) begin
        n_err++; $display("FAIL dump_addr[%0d] got=%h exp=%h", i, mem_address, exp_a[i]);
      end
      n_cmp++; if (mem_load !== 1'b0) begin n_err++; $display("FAIL dump_we[%0d] got=%b exp=0", i, mem_load); end
      adv();
    end
    mid();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL dump_done got=%b exp=1", done); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL dump_valid_end got=%b exp=0", m_valid); end
    adv();
    m_ready = 1'b0;
  endtask

  task automatic test_dump_stall();
    logic          rdy [5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [DW-1:0] exp_d [5] = '{16'h0101, 16'h0202, 16'h0202, 16'h0202, 16'h0303};
    logic [AW-1:0] exp_a [5] = '{9'h101, 9'h102, 9'h102, 9'h102, 9'h103};
    ext_write(9'h100, 16'h0101);
    ext_write(9'h101, 16'h0202);
    ext_write(9'h102, 16'h0303);
    m_ready = 1'b0;
    do_start(1'b1, 9'h100, 10'd3);
    adv();
    for (int i = 0; i < 5; i++) begin
      m_ready = rdy[i];
      mid();
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, m_valid); end
      n_cmp++; if (m_data !== exp_d[i]) begin
        n_err++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, m_data, exp_d[i]);
      end
      n_cmp++; if (mem_address !== exp_a[i]) begin
        n_err++; $display("FAIL stall_addr[%0d] got=%h exp=%h", i, mem_address, exp_a[i]);
      end
      adv();
    end
    m_ready = 1'b0;
    mid();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done got=%b exp=1", done); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid_end got=%b exp=0", m_valid); end
    adv();
  endtask

  task automatic test_count_zero();
    int snap;
    snap = wr_cnt;
    s_valid = 1'b1;
    s_data = 16'h5A5A;
    do_start(1'b0, 9'h010, 10'd0);
    // start while the block is still busy (DONE) must be ignored
    start = 1'b1; mode = 1'b0; base = 9'h010; count = 10'd3;
    mid();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done got=%b exp=1", done); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy got=%b exp=1", busy); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL zero_s_ready got=%b exp=0", s_ready); end
    n_cmp++; if (mem_load !== 1'b0) begin n_err++; $display("FAIL zero_we got=%b exp=0", mem_load); end
    adv();
    start = 1'b0;
    mid();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_ignored got=%b exp=0", busy); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL zero_s_ready_after got=%b exp=0", s_ready); end
    adv();
    s_valid = 1'b0;
    n_cmp++; if (wr_cnt - snap !== 0) begin n_err++; $display("FAIL zero_wr_cnt got=%0d exp=0", wr_cnt - snap); end
  endtask

  task automatic test_reset_mid_load();
    int snap;
    ext_write(9'h043, 16'hDEAD);
    snap = wr_cnt;
    s_valid = 1'b1;
    do_start(1'b0, 9'h040, 10'd8);
    for (int i = 0; i < 3; i++) begin
      s_data = 16'h0E01 + DW'(i);
      adv();
    end
    s_data = 16'h0E04;
    rst = 1'b1;
    mid();
    n_cmp++; if (mem_load !== 1'b0) begin n_err++; $display("FAIL rstmid_we got=%b exp=0", mem_load); end
    adv();
    rst = 1'b0;
    mid();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b exp=0", done); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_s_ready got=%b exp=0", s_ready); end
    n_cmp++; if (mem_load !== 1'b0) begin n_err++; $display("FAIL rstmid_we_after got=%b exp=0", mem_load); end
    n_cmp++; if (mem_address !== 9'h0) begin n_err++; $display("FAIL rstmid_addr got=%h exp=0", mem_address); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_m_valid got=%b exp=0", m_valid); end
    adv();
    s_valid = 1'b0;
    n_cmp++; if (wr_cnt - snap !== 3) begin n_err++; $display("FAIL rstmid_wr_cnt got=%0d exp=3", wr_cnt - snap); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ram[9'h040 + i] !== 16'h0E01 + DW'(i)) begin
        n_err++; $display("FAIL rstmid_ram[%0d] got=%h exp=%h", i, ram[9'h040 + i], 16'h0E01 + DW'(i));
      end
    end
    n_cmp++; if (ram[9'h043] !== 16'hDEAD) begin n_err++; $display("FAIL rstmid_ram3 got=%h exp=dead", ram[9'h043]); end
  endtask

`ifdef RAM_STREAM_PORT_VERIFY_EN
  task automatic verify_run(input logic [AW-1:0] b, input bit corrupt, input logic exp_err);
    int n;
    s_valid = 1'b1;
    do_start(1'b0, b, 10'd2);
    s_data = 16'h1234;
    mid();
    n_cmp++; if (verify_err !== 1'b0) begin n_err++; $display("FAIL verr_cleared got=%b exp=0", verify_err); end
    adv();
    s_data = 16'h0F0F;
    adv();
    s_valid = 1'b0;
    if (corrupt) begin
      ext_write(b, 16'h9999);
    end else begin
      adv();
    end
    wait_done(n);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL verr_latency got=%0d exp=3", n); end
    n_cmp++; if (verify_err !== exp_err) begin
      n_err++; $display("FAIL verr_at_done got=%b exp=%b", verify_err, exp_err);
    end
    adv();
    adv();
    mid();
    n_cmp++; if (verify_err !== exp_err) begin
      n_err++; $display("FAIL verr_hold got=%b exp=%b", verify_err, exp_err);
    end
    adv();
  endtask

  task automatic test_verify();
    verify_run(9'h060, 1'b1, 1'b1);
    verify_run(9'h070, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_dump_wrap();
    test_dump_stall();
    test_count_zero();
`ifdef RAM_STREAM_PORT_VERIFY_EN
    test_verify();
`endif
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
